// File: rtl/seven_segment_scan_controller_if.sv
// rtl/seven_segment_scan_controller_if.sv - value/control inputs and display outputs of the scan controller
interface seven_segment_scan_controller_if;
  logic        Load;
  logic [15:0] Value;
  logic [3:0]  DpIn;
  logic [3:0]  DigitEnable;
  logic        LzbEn;
  logic [3:0]  Nibble;
  logic [3:0]  Anodes;
  logic        DpOut;
  logic        FrameStart;

  modport master (
    output Load, Value, DpIn, DigitEnable, LzbEn,
    input  Nibble, Anodes, DpOut, FrameStart
  );

  modport slave (
    input  Load, Value, DpIn, DigitEnable, LzbEn,
    output Nibble, Anodes, DpOut, FrameStart
  );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// rtl/seven_segment_scan_controller.sv - 4-digit common-anode scan with blanking, LZ suppression and frame-synchronous load
module seven_segment_scan_controller #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  seven_segment_scan_controller_if.slave bus
);
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;
  localparam state_t ST_SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  // r_cnt/r_idx/r_state describe the slot position presented after the next edge
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  state_t        r_state;
  logic [15:0]   r_display;
  logic [3:0]    r_display_dp;
  logic [15:0]   r_pend;
  logic [3:0]    r_pend_dp;
  logic          r_pend_valid;

  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_idx_nxt;
  state_t        w_state_nxt;
  logic          w_frame_start;
  logic          w_commit;
  logic [15:0]   w_disp;
  logic [3:0]    w_disp_dp;
  logic [3:0]    w_nibble;
  logic          w_lz_blank;
  logic          w_shown;
  logic [3:0]    w_anodes;
  logic          w_dp;

  always_comb begin
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_state_nxt = r_state;
    if (r_cnt == LAST_CNT) begin
      w_cnt_nxt   = '0;
      w_idx_nxt   = r_idx + 2'd1;
      w_state_nxt = ST_SLOT_START;
    end else if (w_cnt_nxt == BLANK_END) begin
      w_state_nxt = ST_DRIVE;
    end
  end

  always_comb begin
    w_frame_start = (r_cnt == '0) && (r_idx == 2'd0);
    w_commit      = w_frame_start && r_pend_valid;
    w_disp        = w_commit ? r_pend    : r_display;
    w_disp_dp     = w_commit ? r_pend_dp : r_display_dp;
    w_nibble      = w_disp[{r_idx, 2'b00} +: 4];

    w_lz_blank = 1'b0;
    case (r_idx)
      2'd3:    w_lz_blank = (w_disp[15:12] == 4'h0);
      2'd2:    w_lz_blank = (w_disp[15:8]  == 8'h00);
      2'd1:    w_lz_blank = (w_disp[15:4]  == 12'h000);
      default: w_lz_blank = 1'b0;
    endcase
    w_shown = bus.DigitEnable[r_idx] && !(bus.LzbEn && w_lz_blank);

    w_anodes = 4'b1111;
    w_dp     = 1'b1;
    if ((r_state == ST_DRIVE) && w_shown) begin
      w_anodes = ~(4'b0001 << r_idx);
      w_dp     = ~w_disp_dp[r_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt          <= '0;
      r_idx          <= 2'd0;
      r_state        <= ST_SLOT_START;
      r_display      <= 16'h0000;
      r_display_dp   <= 4'h0;
      r_pend         <= 16'h0000;
      r_pend_dp      <= 4'h0;
      r_pend_valid   <= 1'b0;
      bus.Nibble     <= 4'h0;
      bus.Anodes     <= 4'b1111;
      bus.DpOut      <= 1'b1;
      bus.FrameStart <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_state      <= w_state_nxt;
      r_display    <= w_disp;
      r_display_dp <= w_disp_dp;
      // A Load on the commit edge re-arms pending; the commit above used the old contents
      if (bus.Load) begin
        r_pend       <= bus.Value;
        r_pend_dp    <= bus.DpIn;
        r_pend_valid <= 1'b1;
      end else if (w_commit) begin
        r_pend_valid <= 1'b0;
      end
      bus.Nibble     <= w_nibble;
      bus.Anodes     <= w_anodes;
      bus.DpOut      <= w_dp;
      bus.FrameStart <= w_frame_start;
    end
  end
endmodule
